shiftreg_scanner: RTL

//  Front end for the button/switch chain: clocks a daisy-chain of 74HC165-style

---
 rtl/shiftreg_pkg.sv | 22 ++
 rtl/sync2.sv | 21 ++
 rtl/shiftreg_scanner.sv | 133 +++++++++++++
 3 files changed

// File: rtl/shiftreg_pkg.sv
// Shared types and register map for the 74HC165 chain scanner.
package shiftreg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SAMPLE,
    ST_SHIFT_HI,
    ST_SHIFT_LO,
    ST_COMMIT
  } scan_state_t;

  localparam logic [1:0] ADDR_STATE     = 2'd0;
  localparam logic [1:0] ADDR_EVENTS    = 2'd1;
  localparam logic [1:0] ADDR_SCANCOUNT = 2'd2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for the asynchronous serial input from the chain.
module sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/shiftreg_scanner.sv
// Scans a daisy-chain of parallel-in/serial-out registers, keeps the latest
// frame and sticky 0->1 edge flags, and exposes them as an Avalon-MM slave.
//
// state     | meaning
// IDLE      | wait SCAN_PERIOD cycles between scans
// LOAD      | loadn low, chain captures its parallel inputs
// SETTLE    | loadn high, let the first bit reach the synchroniser
// SAMPLE    | shift one synchronised bit into the frame
// SHIFT_HI  | shift clock high, chain advances on the rising edge
// SHIFT_LO  | shift clock low, next bit settles
// COMMIT    | publish frame, accumulate edges, bump scan count
module shiftreg_scanner
  import shiftreg_pkg::*;
#(
  parameter int NUM_BITS    = 16,
  parameter int CLK_DIV     = 25,
  parameter int SCAN_PERIOD = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  output logic        shiftreg_clk,
  output logic        shiftreg_loadn,
  input  logic        shiftreg_out,
  output logic        frame_valid
);

  localparam int CNT_W = $clog2(max_int(CLK_DIV, SCAN_PERIOD) + 1);
  localparam int BIT_W = $clog2(NUM_BITS + 1);
  localparam logic [CNT_W-1:0] IDLE_TC = CNT_W'(SCAN_PERIOD - 1);
  localparam logic [CNT_W-1:0] DIV_TC  = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_TC = BIT_W'(NUM_BITS - 1);

  scan_state_t         state, state_nxt;
  logic [CNT_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [NUM_BITS-1:0] frame, state_bits, events, new_edges, events_clr;
  logic [31:0]         scan_count, rd_value;
  logic                sync_out, last_bit;
  logic                clk_d, loadn_d, valid_d;

  sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (shiftreg_out),
    .q       (sync_out)
  );

  assign last_bit = (bit_cnt == LAST_TC);

  // Pad outputs are registered from the next state so they never glitch
  // yet line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      div_cnt        <= '0;
      shiftreg_clk   <= 1'b0;
      shiftreg_loadn <= 1'b1;
      frame_valid    <= 1'b0;
    end else begin
      state          <= state_nxt;
      div_cnt        <= (state_nxt != state) ? '0 : div_cnt + CNT_W'(1);
      shiftreg_clk   <= clk_d;
      shiftreg_loadn <= loadn_d;
      frame_valid    <= valid_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (div_cnt == IDLE_TC) state_nxt = ST_LOAD;
      ST_LOAD:     if (div_cnt == DIV_TC)  state_nxt = ST_SETTLE;
      ST_SETTLE:   if (div_cnt == DIV_TC)  state_nxt = ST_SAMPLE;
      ST_SAMPLE:   state_nxt = last_bit ? ST_COMMIT : ST_SHIFT_HI;
      ST_SHIFT_HI: if (div_cnt == DIV_TC)  state_nxt = ST_SHIFT_LO;
      ST_SHIFT_LO: if (div_cnt == DIV_TC)  state_nxt = ST_SAMPLE;
      ST_COMMIT:   state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    clk_d   = (state_nxt == ST_SHIFT_HI);
    loadn_d = (state_nxt != ST_LOAD);
    valid_d = (state_nxt == ST_COMMIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      frame   <= '0;
    end else if (state == ST_LOAD) begin
      bit_cnt <= '0;
    end else if (state == ST_SAMPLE) begin
      bit_cnt <= bit_cnt + BIT_W'(1);
      frame   <= (frame << 1) | NUM_BITS'(sync_out);
    end
  end

  assign new_edges  = (state == ST_COMMIT) ? (frame & ~state_bits) : '0;
  assign events_clr = (avs_read && avs_address == ADDR_EVENTS) ? events : '0;

  always_comb begin
    rd_value = '0;
    case (avs_address)
      ADDR_STATE:     rd_value = 32'(state_bits);
      ADDR_EVENTS:    rd_value = 32'(events);
      ADDR_SCANCOUNT: rd_value = scan_count;
      default:        rd_value = '0;
    endcase
  end

  // An edge committed in the same cycle as an EVENTS read survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_bits   <= '0;
      events       <= '0;
      scan_count   <= '0;
      avs_readdata <= '0;
    end else begin
      events <= (events & ~events_clr) | new_edges;
      if (state == ST_COMMIT) begin
        state_bits <= frame;
        scan_count <= scan_count + 32'd1;
      end
      if (avs_read) avs_readdata <= rd_value;
    end
  end

endmodule
